// File: rtl/deparse_hdr_merger.sv
// Merges 2B/4B/6B PHV fields from sub_deparser into a buffered 128-byte packet header,
// then presents the merged header on a valid/ready output.
module deparse_hdr_merger #(
   parameter int unsigned C_HDR_WIDTH    = 1024,
   parameter int unsigned C_OFFSET_WIDTH = 7,
   parameter int unsigned C_MAX_FIELDS   = 10
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [C_HDR_WIDTH-1:0]    i_hdr_in,
   input  logic                      i_hdr_in_nofield,
   input  logic                      i_hdr_in_valid,
   output logic                      o_hdr_in_ready,
   input  logic [47:0]               i_field_in,
   input  logic [1:0]                i_field_select,
   input  logic                      i_field_valid,
   input  logic [C_OFFSET_WIDTH-1:0] i_field_offset,
   input  logic                      i_field_last,
   output logic [C_HDR_WIDTH-1:0]    o_hdr_out,
   output logic                      o_hdr_out_valid,
   input  logic                      i_hdr_out_ready,
   output logic                      o_err_drop,
   output logic                      o_err_range
);

   localparam int unsigned LP_BYTES = C_HDR_WIDTH / 8;
   localparam int unsigned LP_CNT_W = $clog2(C_MAX_FIELDS + 1);
   localparam logic [LP_CNT_W-1:0] LP_CNT_LAST = LP_CNT_W'(C_MAX_FIELDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MERGE,
      ST_OUTPUT
   } state_t;

   state_t                r_state;
   logic [C_HDR_WIDTH-1:0] r_buf;
   logic [LP_CNT_W-1:0]   r_cnt;
   logic                  r_hdr_in_ready;
   logic                  r_out_valid;
   logic                  r_err_drop;
   logic                  r_err_range;

   logic [C_HDR_WIDTH-1:0] w_merged;
   logic                   w_range;
   logic [2:0]             w_width;

   // Field byte 0 is the most significant byte and lands at the lowest offset.
   always_comb begin
      case (i_field_select)
         2'b01:   w_width = 3'd2;
         2'b10:   w_width = 3'd4;
         2'b11:   w_width = 3'd6;
         default: w_width = 3'd0;
      endcase
      w_merged = r_buf;
      w_range  = 1'b0;
      for (int unsigned j = 0; j < 6; j++) begin
         if (j < 32'(w_width)) begin
            if (32'(i_field_offset) + j < LP_BYTES) begin
               w_merged[(32'(i_field_offset) + j) * 8 +: 8] =
                  i_field_in[(32'(w_width) - 1 - j) * 8 +: 8];
            end else begin
               w_range = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= ST_IDLE;
         r_buf          <= '0;
         r_cnt          <= '0;
         r_hdr_in_ready <= 1'b0;
         r_out_valid    <= 1'b0;
         r_err_drop     <= 1'b0;
         r_err_range    <= 1'b0;
      end else begin
         r_err_drop  <= i_field_valid && (r_state != ST_MERGE);
         r_err_range <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // r_hdr_in_ready is low only in the first cycle out of reset
               if (r_hdr_in_ready && i_hdr_in_valid) begin
                  r_buf          <= i_hdr_in;
                  r_cnt          <= '0;
                  r_hdr_in_ready <= 1'b0;
                  if (i_hdr_in_nofield) begin
                     r_state     <= ST_OUTPUT;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_state <= ST_MERGE;
                  end
               end else begin
                  r_hdr_in_ready <= 1'b1;
               end
            end
            ST_MERGE: begin
               if (i_field_valid) begin
                  r_buf       <= w_merged;
                  r_err_range <= w_range;
                  r_cnt       <= r_cnt + 1'b1;
                  if (i_field_last || (r_cnt == LP_CNT_LAST)) begin
                     r_state     <= ST_OUTPUT;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            ST_OUTPUT: begin
               if (i_hdr_out_ready) begin
                  r_state        <= ST_IDLE;
                  r_out_valid    <= 1'b0;
                  r_hdr_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state        <= ST_IDLE;
               r_out_valid    <= 1'b0;
               r_hdr_in_ready <= 1'b0;
            end
         endcase
      end
   end

   assign o_hdr_in_ready  = r_hdr_in_ready;
   assign o_hdr_out       = r_buf;
   assign o_hdr_out_valid = r_out_valid;
   assign o_err_drop      = r_err_drop;
   assign o_err_range     = r_err_range;

endmodule

// File: tb/tb_deparse_hdr_merger.sv
// Bench for deparse_hdr_merger: byte-array packet model checked every cycle, plus directed
// vectors with hand-computed headers.
module tb_deparse_hdr_merger;

   logic          clk = 1'b0;
   logic          rst;
   logic [1023:0] hdr_in;
   logic          hdr_in_nofield;
   logic          hdr_in_valid;
   logic          hdr_in_ready;
   logic [47:0]   field_in;
   logic [1:0]    field_select;
   logic          field_valid;
   logic [6:0]    field_offset;
   logic          field_last;
   logic [1023:0] hdr_out;
   logic          hdr_out_valid;
   logic          hdr_out_ready;
   logic          err_drop;
   logic          err_range;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   deparse_hdr_merger #(
      .C_HDR_WIDTH   (1024),
      .C_OFFSET_WIDTH(7),
      .C_MAX_FIELDS  (10)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_hdr_in        (hdr_in),
      .i_hdr_in_nofield(hdr_in_nofield),
      .i_hdr_in_valid  (hdr_in_valid),
      .o_hdr_in_ready  (hdr_in_ready),
      .i_field_in      (field_in),
      .i_field_select  (field_select),
      .i_field_valid   (field_valid),
      .i_field_offset  (field_offset),
      .i_field_last    (field_last),
      .o_hdr_out       (hdr_out),
      .o_hdr_out_valid (hdr_out_valid),
      .i_hdr_out_ready (hdr_out_ready),
      .o_err_drop      (err_drop),
      .o_err_range     (err_range)
   );

   task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_hdr(input string name, input logic [1023:0] got,
                            input logic [1023:0] exp);
      int idx;
      n_total++;
      if (got !== exp) begin
         n_bad++;
         idx = 0;
         for (int k = 127; k >= 0; k--) if (got[k*8 +: 8] !== exp[k*8 +: 8]) idx = k;
         $display("FAIL %s: byte %0d got %02h want %02h at %0t", name, idx,
                  got[idx*8 +: 8], exp[idx*8 +: 8], $time);
      end
   endtask

   // Packet-level model: mode 0 = waiting for header, 1 = collecting fields, 2 = holding output
   int          m_mode;
   logic [7:0]  m_bytes [128];
   int          m_cnt;
   int          m_w;
   int          m_p;
   logic        e_ready, e_valid, e_drop, e_range;
   logic        m_was_rst;

   function automatic logic [1023:0] model_hdr();
      logic [1023:0] v;
      for (int k = 0; k < 128; k++) v[k*8 +: 8] = m_bytes[k];
      return v;
   endfunction

   always @(posedge clk) begin
      m_was_rst = rst;
      if (rst) begin
         m_mode  = 0;
         m_cnt   = 0;
         e_ready = 1'b0;
         e_valid = 1'b0;
         e_drop  = 1'b0;
         e_range = 1'b0;
         for (int k = 0; k < 128; k++) m_bytes[k] = 8'h00;
      end else begin
         e_drop  = field_valid && (m_mode != 1);
         e_range = 1'b0;
         if (m_mode == 0) begin
            if (e_ready && hdr_in_valid) begin
               for (int k = 0; k < 128; k++) m_bytes[k] = hdr_in[k*8 +: 8];
               m_cnt  = 0;
               m_mode = hdr_in_nofield ? 2 : 1;
            end
         end else if (m_mode == 1) begin
            if (field_valid) begin
               m_w = 2 * int'(field_select);
               for (int j = 0; j < m_w; j++) begin
                  m_p = int'(field_offset) + j;
                  if (m_p < 128) m_bytes[m_p] = field_in[8*(m_w-1-j) +: 8];
                  else e_range = 1'b1;
               end
               m_cnt++;
               if (field_last || m_cnt == 10) m_mode = 2;
            end
         end else begin
            if (hdr_out_ready) m_mode = 0;
         end
         e_ready = (m_mode == 0);
         e_valid = (m_mode == 2);
      end
      #1;
      check("hdr_in_ready", 48'(hdr_in_ready), 48'(e_ready));
      check("hdr_out_valid", 48'(hdr_out_valid), 48'(e_valid));
      check("err_drop", 48'(err_drop), 48'(e_drop));
      check("err_range", 48'(err_range), 48'(e_range));
      if (e_valid || m_was_rst) check_hdr("hdr_out_model", hdr_out, model_hdr());
   end

   task automatic send_hdr(input logic [1023:0] h, input logic nf);
      int waited = 0;
      while (hdr_in_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (hdr_in_ready !== 1'b1) begin
         n_total++;
         n_bad++;
         $display("FAIL hdr_accept_timeout: ready=%b after %0d cycles", hdr_in_ready, waited);
      end
      hdr_in         = h;
      hdr_in_nofield = nf;
      hdr_in_valid   = 1'b1;
      @(negedge clk);
      hdr_in_valid   = 1'b0;
      hdr_in_nofield = 1'b0;
   endtask

   task automatic send_field(input logic [1:0] sel, input logic [6:0] off,
                             input logic [47:0] val, input logic last);
      field_select = sel;
      field_offset = off;
      field_in     = val;
      field_last   = last;
      field_valid  = 1'b1;
      @(negedge clk);
      field_valid  = 1'b0;
      field_last   = 1'b0;
      field_select = 2'b00;
   endtask

   task automatic release_out();
      hdr_out_ready = 1'b1;
      @(negedge clk);
      hdr_out_ready = 1'b0;
   endtask

   logic [7:0]    mix_exp [14] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hDE, 8'hAD,
                                   8'hBE, 8'hEF, 8'hFF, 8'hFF, 8'h08, 8'h00};
   logic [1023:0] exp_v;
   logic [1023:0] pat;
   logic [1023:0] flush_v;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      hdr_in         = '0;
      hdr_in_nofield = 1'b0;
      hdr_in_valid   = 1'b0;
      field_in       = '0;
      field_select   = 2'b00;
      field_valid    = 1'b0;
      field_offset   = '0;
      field_last     = 1'b0;
      hdr_out_ready  = 1'b0;
      for (int k = 0; k < 128; k++) pat[k*8 +: 8] = 8'(k * 3 + 1);

      repeat (3) @(negedge clk);
      check("ready_in_reset", 48'(hdr_in_ready), 48'd0);
      check_hdr("hdr_out_reset", hdr_out, '0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 48'(hdr_in_ready), 48'd1);

      // Basic 2B write
      send_hdr('0, 1'b0);
      send_field(2'b01, 7'd12, 48'h0000_0000_ABCD, 1'b1);
      exp_v = '0;
      exp_v[12*8 +: 8] = 8'hAB;
      exp_v[13*8 +: 8] = 8'hCD;
      check("basic_valid", 48'(hdr_out_valid), 48'd1);
      check_hdr("basic_hdr", hdr_out, exp_v);
      release_out();

      // Mixed back-to-back 6B/4B/2B
      send_hdr({128{8'hFF}}, 1'b0);
      send_field(2'b11, 7'd0, 48'h1122_3344_5566, 1'b0);
      send_field(2'b10, 7'd6, 48'h0000_DEAD_BEEF, 1'b0);
      check("mixed_not_yet", 48'(hdr_out_valid), 48'd0);
      send_field(2'b01, 7'd12, 48'h0000_0000_0800, 1'b1);
      exp_v = {128{8'hFF}};
      for (int k = 0; k < 14; k++) exp_v[k*8 +: 8] = mix_exp[k];
      check("mixed_valid", 48'(hdr_out_valid), 48'd1);
      check_hdr("mixed_hdr", hdr_out, exp_v);
      release_out();

      // Boundary at offset 125
      send_hdr({128{8'h5A}}, 1'b0);
      send_field(2'b11, 7'd125, 48'hA1A2_A3A4_A5A6, 1'b1);
      exp_v = {128{8'h5A}};
      exp_v[125*8 +: 8] = 8'hA1;
      exp_v[126*8 +: 8] = 8'hA2;
      exp_v[127*8 +: 8] = 8'hA3;
      check("boundary_err_range", 48'(err_range), 48'd1);
      check_hdr("boundary_hdr", hdr_out, exp_v);
      release_out();
      check("boundary_err_range_pulse", 48'(err_range), 48'd0);

      // Overlap and forced flush after ten fields
      send_hdr('0, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         send_field(2'b01, 7'd0, 48'(i), 1'b0);
         if (i == 9) check("flush_not_yet", 48'(hdr_out_valid), 48'd0);
      end
      flush_v = '0;
      flush_v[1*8 +: 8] = 8'h0A;
      check("flush_valid", 48'(hdr_out_valid), 48'd1);
      check_hdr("flush_hdr", hdr_out, flush_v);

      // Backpressure with stray fields in OUTPUT
      for (int i = 0; i < 5; i++) begin
         send_field(2'b11, 7'd0, 48'hFFFF_FFFF_FFFF, 1'b0);
         check("stray_err_drop", 48'(err_drop), 48'd1);
         check_hdr("stray_hdr_stable", hdr_out, flush_v);
      end
      release_out();
      check("bp_valid_drop", 48'(hdr_out_valid), 48'd0);
      check("bp_ready_back", 48'(hdr_in_ready), 48'd1);

      // nofield header passes straight through
      send_hdr(pat, 1'b1);
      check("nofield_valid", 48'(hdr_out_valid), 48'd1);
      check_hdr("nofield_hdr", hdr_out, pat);
      release_out();

      // Field coinciding with header acceptance is dropped; select 00 still ends the packet
      hdr_in       = ~pat;
      hdr_in_valid = 1'b1;
      field_valid  = 1'b1;
      field_select = 2'b11;
      field_in     = 48'h0102_0304_0506;
      @(negedge clk);
      hdr_in_valid = 1'b0;
      field_valid  = 1'b0;
      field_select = 2'b00;
      check("accept_cycle_drop", 48'(err_drop), 48'd1);
      send_field(2'b00, 7'd5, 48'h12_3456, 1'b1);
      check("sel00_valid", 48'(hdr_out_valid), 48'd1);
      check_hdr("sel00_hdr", hdr_out, ~pat);
      release_out();

      // Reset in the middle of a packet
      send_hdr(pat, 1'b0);
      send_field(2'b10, 7'd20, 48'h0000_CAFE_BABE, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_valid", 48'(hdr_out_valid), 48'd0);
      check("rst_mid_ready", 48'(hdr_in_ready), 48'd0);
      check_hdr("rst_mid_hdr", hdr_out, '0);
      @(negedge clk);
      check("rst_mid_ready_after", 48'(hdr_in_ready), 48'd1);
      repeat (3) @(negedge clk);
      check("rst_mid_no_output", 48'(hdr_out_valid), 48'd0);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
